// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared types and constants for the sequential CLA adder.
//   state_e : sequencer states (IDLE, RUN, DONE)
//   SLICE_W : number of bits the shared lookahead slice adds per cycle
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 2;

endpackage

// File: rtl/cla_seq_adder_cla_2.sv
// cla_2: 2-bit carry-lookahead adder slice (purely combinational).
//   a, b : 2-bit addends
//   cin  : carry into bit 0
//   s    : 2-bit sum
//   cout : carry out of bit 1, computed by lookahead rather than ripple
module cla_2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  logic [1:0] g_s;
  logic [1:0] p_s;
  logic       c1_s;

  // Generate/propagate terms and lookahead carries for both bit positions
  always_comb begin
    g_s  = a & b;
    p_s  = a ^ b;
    c1_s = g_s[0] | (p_s[0] & cin);
    cout = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    s    = p_s ^ {c1_s, cin};
  end

endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle WIDTH-bit adder that reuses one 2-bit
// carry-lookahead slice, processing 2 bits per cycle LSB-first.
// Latency is WIDTH/2 cycles from operand accept to out_valid.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
//   ovf                 : signed overflow, present only when the macro
//                         CLA_SEQ_OVF_EN is defined
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / SLICE_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be even and >= 2");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [1:0]       slice_s;
  logic             slice_c;
`ifdef CLA_SEQ_OVF_EN
  logic [1:0]       msb_q, msb_d;
  logic             ovf_q, ovf_d;
`endif

  cla_2 u_slice (
    .a    (a_sh_q[1:0]),
    .b    (b_sh_q[1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef CLA_SEQ_OVF_EN
    msb_d   = msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        // in_ready is implied by IDLE, so in_valid alone is the handshake
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
`ifdef CLA_SEQ_OVF_EN
          msb_d   = {a[WIDTH-1], b[WIDTH-1]};
`endif
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Slice result enters at the top so that after N steps the first
        // (least significant) slice has shifted down to bits [1:0].
        a_sh_d  = a_sh_q >> SLICE_W;
        b_sh_d  = b_sh_q >> SLICE_W;
        sum_d   = sum_q >> SLICE_W;
        sum_d[WIDTH-1 -: SLICE_W] = slice_s;
        carry_d = slice_c;
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = DONE;
`ifdef CLA_SEQ_OVF_EN
          // a^b^sum at the MSB is the carry into the MSB; xor with carry-out
          ovf_d   = msb_q[1] ^ msb_q[0] ^ slice_s[1] ^ slice_c;
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      msb_q   <= 2'b00;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef CLA_SEQ_OVF_EN
      msb_q   <= msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;
`ifdef CLA_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: directed self-checking bench for cla_seq_adder (WIDTH=16).
// Inputs change and outputs are sampled on the falling clock edge.
// Overflow checks are compiled in when CLA_SEQ_OVF_EN is defined.
module tb_cla_seq_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf;
`endif

  int checks   = 0;
  int failures = 0;
  int n;

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts falling edges until out_valid is seen, bounded at 40
  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 40);
  endtask

  // One full operation: accept, latency, result, handshake
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    in_valid = 1'b1; a = ta; b = tb_v; cin = tc;
    @(negedge clk);
    in_valid = 1'b0;
    chk1({tag, "_busy"}, in_ready, 1'b0);
    wait_valid(lat);
    chk_int({tag, "_lat"}, lat, 8);
    chk16({tag, "_sum"}, sum, es);
    chk1({tag, "_cout"}, cout, ec);
`ifdef CLA_SEQ_OVF_EN
    chk1({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) chk1({tag, "_eo"}, eo, 1'b0);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1({tag, "_ov_clr"}, out_valid, 1'b0);
    chk1({tag, "_rdy"}, in_ready, 1'b1);
    chk16({tag, "_hold"}, sum, es);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'h0000; b = 16'h0000; cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk16("rst_sum", sum, 16'h0000);
    chk1("rst_cout", cout, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with backpressure and in_valid asserted during DONE
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(n);
    chk_int("bp_lat", n, 8);
    chk16("bp_sum", sum, 16'h5555);
    chk1("bp_cout", cout, 1'b0);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'hAAAA; cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("bp_valid", out_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk16("bp_sum_hold", sum, 16'h5555);
      chk1("bp_cout_hold", cout, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("bp_idle_rdy", in_ready, 1'b1);
    chk1("bp_idle_ov", out_valid, 1'b0);
    chk16("bp_after_hs", sum, 16'h5555);

    // Full carry ripple
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("cin_rip", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Reset after step 3 of 0xFFFF+0xFFFF: partial sum top byte is 0xFE
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk16("mid_partial", sum, 16'hFE00);
    chk1("mid_carry", cout, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_ov", out_valid, 1'b0);
    chk1("mid_rst_rdy", in_ready, 1'b1);
    chk16("mid_rst_sum", sum, 16'h0000);
    chk1("mid_rst_cout", cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h0003; b = 16'h0001; cin = 1'b0;
    @(negedge clk);
    a = 16'h8000; b = 16'h8000;
    wait_valid(n);
    chk_int("b2b_lat1", n, 8);
    chk16("b2b_sum1", sum, 16'h0004);
    chk1("b2b_cout1", cout, 1'b0);
    wait_valid(n);
    chk_int("b2b_space", n, 10);
    chk16("b2b_sum2", sum, 16'h0000);
    chk1("b2b_cout2", cout, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("b2b_idle_rdy", in_ready, 1'b1);
    chk1("b2b_idle_ov", out_valid, 1'b0);

    // Signed overflow cases (ovf compared only when the feature is built)
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("ovf_none", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
